// File: rtl/serial_parity_transmitter_pkg.sv
// Shared definitions for the serial parity link (transmitter and checker).
package serial_parity_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam bit MODE_EVEN = 1'b0;
  localparam bit MODE_ODD  = 1'b1;

  // Parity bit on the wire given the accumulated XOR of the data bits.
  function automatic logic parity_bit(input logic acc, input bit mode);
    return acc ^ mode;
  endfunction

endpackage

// File: rtl/parity_accumulator.sv
// Running parity toggle register: flips on each enabled 1, holds on 0.
module parity_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic par
);

  // Clear wins over enable so a word load always starts from zero.
  always_ff @(posedge clk) begin
    if (!rst)          par <= 1'b0;
    else if (clr)      par <= 1'b0;
    else if (en && din) par <= ~par;
  end

endmodule

// File: rtl/serial_parity_transmitter.sv
// Serial parity transmitter: LSB-first data bits followed by one parity bit.
module serial_parity_transmitter
  import serial_parity_transmitter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit ODD   = MODE_EVEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             out,
  output logic             valid,
  output logic             is_parity,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             par;
  logic             accept;
  logic             last;
  logic             par_next;

  // ready is only high in IDLE and PARITY, so this is the accept condition.
  assign accept   = start && ready;
  assign last     = (cnt == CNT_W'(WIDTH-1));
  assign par_next = par ^ sh[0];

  parity_accumulator u_acc (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == DATA),
    .din (sh[0]),
    .par (par)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      out       <= 1'b0;
      valid     <= 1'b0;
      ready     <= 1'b1;
      is_parity <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, PARITY: begin
          if (accept) begin
            state     <= DATA;
            sh        <= data;
            cnt       <= '0;
            out       <= data[0];
            valid     <= 1'b1;
            ready     <= 1'b0;
            is_parity <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state     <= IDLE;
            out       <= 1'b0;
            valid     <= 1'b0;
            ready     <= 1'b1;
            is_parity <= 1'b0;
            busy      <= 1'b0;
          end
        end
        DATA: begin
          sh  <= sh >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            // Parity register lags by one bit, so fold in the last data bit here.
            state     <= PARITY;
            out       <= parity_bit(par_next, ODD);
            is_parity <= 1'b1;
            ready     <= 1'b1;
          end else begin
            out <= sh[1];
          end
        end
        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          valid     <= 1'b0;
          ready     <= 1'b1;
          is_parity <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
